// File: rtl/seq_alu_if.sv
// -----------------------------------------------------------------------------
// seq_alu_if -- request/response bundle for the sequential ALU.
//
// Signals:
//   in_valid   requester -> ALU   request present (Operation, a, b valid)
//   in_ready   ALU -> requester   ALU can accept a request
//   Operation  requester -> ALU   4-bit ALU operation code
//   a, b       requester -> ALU   WIDTH-bit operands (b[log2(WIDTH)-1:0] = shamt)
//   out_valid  ALU -> consumer    Result/Zero valid
//   out_ready  consumer -> ALU    consumer accepts the result
//   Result     ALU -> consumer    WIDTH-bit registered result
//   Zero       ALU -> consumer    registered (Result == 0)
//
// Modports: master = requester/consumer side, slave = the ALU.
// -----------------------------------------------------------------------------
interface seq_alu_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       Operation;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             Zero;

    modport master (
        output in_valid, Operation, a, b, out_ready,
        input  in_ready, out_valid, Result, Zero
    );

    modport slave (
        input  in_valid, Operation, a, b, out_ready,
        output in_ready, out_valid, Result, Zero
    );
endinterface

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- sequential ALU with valid/ready handshakes on both sides.
//
// AND/OR/ADD/SUB complete in one cycle; SLL runs in a SHIFT state one bit per
// cycle. The unit holds one operation at a time: IDLE accepts, DONE presents
// Result/Zero until the consumer takes them.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    seq_alu_if.slave (in_valid/in_ready/Operation/a/b,
//          out_valid/out_ready/Result/Zero)
//
// Configuration:
//   SEQ_ALU_SRL_EN  when defined, opcode 1001 is a logical right shift run in
//                   SHIFT with the same timing as SLL; otherwise 1001 is an
//                   unknown code and yields 0 in one cycle.
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 64
) (
    input  logic      clk,
    input  logic      reset,
    seq_alu_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1000;
`ifdef SEQ_ALU_SRL_EN
    localparam logic [3:0] OP_SRL = 4'b1001;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] work;
    logic [SW-1:0]    count;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
`ifdef SEQ_ALU_SRL_EN
    logic             shift_right;
`endif

    logic             accept;
    logic             is_shift_op;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] work_step;
    logic [SW-1:0]    count_step;
    logic             shift_last;

    assign accept     = bus.in_valid && bus.in_ready;
    assign bus.Result = result_q;
    assign bus.Zero   = zero_q;

    // Single-cycle operations; shift opcodes are handled by the SHIFT state.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        alu_result  = '0;
        is_shift_op = (bus.Operation == OP_SLL);
`ifdef SEQ_ALU_SRL_EN
        is_shift_op = is_shift_op || (bus.Operation == OP_SRL);
`endif
        case (bus.Operation)
            OP_AND:  alu_result = bus.a & bus.b;
            OP_OR:   alu_result = bus.a | bus.b;
            OP_ADD:  alu_result = bus.a + bus.b;
            OP_SUB:  alu_result = bus.a - bus.b;
            default: alu_result = '0;
        endcase
    end

    // One shift step: a bit is moved only while count is non-zero, so a zero
    // shift amount still spends one SHIFT cycle and returns a unchanged. The
    // operation finishes on the edge where the count reaches zero.
    always_comb begin
        work_step  = work;
        count_step = count;
        if (count != '0) begin
`ifdef SEQ_ALU_SRL_EN
            work_step = shift_right ? (work >> 1) : (work << 1);
`else
            work_step = work << 1;
`endif
            count_step = count - 1'b1;
        end
        shift_last = (count_step == '0);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state is written with non-blocking assignments
            // so every flop samples pre-edge values regardless of block order.
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = is_shift_op ? SHIFT : DONE;
            SHIFT:   if (shift_last) next_state = DONE;
            DONE:    if (bus.out_valid && bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs, decoded from state only.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    // Datapath: operands are only looked at in IDLE, so changes on the request
    // side during SHIFT or DONE cannot disturb the operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            work     <= '0;
            count    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
`ifdef SEQ_ALU_SRL_EN
            shift_right <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_shift_op) begin
                            work  <= bus.a;
                            count <= bus.b[SW-1:0];
`ifdef SEQ_ALU_SRL_EN
                            shift_right <= (bus.Operation == OP_SRL);
`endif
                        end else begin
                            result_q <= alu_result;
                            zero_q   <= (alu_result == '0);
                        end
                    end
                end
                SHIFT: begin
                    work  <= work_step;
                    count <= count_step;
                    if (shift_last) begin
                        result_q <= work_step;
                        zero_q   <= (work_step == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu -- self-checking bench for seq_alu (WIDTH = 64).
// Expected result/zero/latency are pushed to a scoreboard queue when a request
// is driven and popped when out_valid appears. Latency is counted as 1 for a
// result visible right after the accept edge, plus one per further edge.
// Define SEQ_ALU_SRL_EN for both bench and RTL to exercise the SRL build.
// -----------------------------------------------------------------------------
module tb_seq_alu;
    localparam int W = 64;

    typedef struct {
        logic [W-1:0] result;
        logic         zero;
        int           lat;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb[$];
    int   total;
    int   bad;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour written from the opcode table.
    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [5:0] sh;
        sh = bv[5:0];
        case (op)
            4'b0000: return av & bv;
            4'b0001: return av | bv;
            4'b0010: return av + bv;
            4'b0110: return av - bv;
            4'b1000: return av << sh;
`ifdef SEQ_ALU_SRL_EN
            4'b1001: return av >> sh;
`endif
            default: return '0;
        endcase
    endfunction

    function automatic int latency(input logic [3:0] op, input logic [W-1:0] bv);
        bit shift_op;
        int sh;
        shift_op = (op == 4'b1000);
`ifdef SEQ_ALU_SRL_EN
        shift_op = shift_op || (op == 4'b1001);
`endif
        sh = int'(bv[5:0]);
        if (!shift_op) return 1;
        // A zero shift amount still spends one cycle in SHIFT.
        return (sh == 0) ? 2 : sh + 1;
    endfunction

    // Issue one request, check result/zero/latency, optionally hold out_ready
    // low for 'hold' cycles in DONE, then check the return to IDLE.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input int hold);
        exp_t e;
        int   lat;
        @(negedge clk);
        check({tag, ".in_ready"}, W'(bus.in_ready), W'(1));
        bus.out_ready = (hold == 0);
        bus.Operation = op;
        bus.a         = av;
        bus.b         = bv;
        bus.in_valid  = 1'b1;
        e.result = model(op, av, bv);
        e.zero   = (e.result == '0);
        e.lat    = latency(op, bv);
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 300) begin
            // Operand churn while busy must not affect the result.
            bus.Operation = 4'($urandom_range(15));
            bus.a         = {$urandom, $urandom};
            bus.b         = {$urandom, $urandom};
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        check({tag, ".latency"}, W'(lat), W'(e.lat));
        check({tag, ".result"}, bus.Result, e.result);
        check({tag, ".zero"}, W'(bus.Zero), W'(e.zero));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.Operation = 4'b0010;
            bus.a         = {$urandom, $urandom};
            bus.b         = {$urandom, $urandom};
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            check({tag, ".hold.out_valid"}, W'(bus.out_valid), W'(1));
            check({tag, ".hold.in_ready"}, W'(bus.in_ready), W'(0));
            check({tag, ".hold.result"}, bus.Result, e.result);
            check({tag, ".hold.zero"}, W'(bus.Zero), W'(e.zero));
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".idle.out_valid"}, W'(bus.out_valid), W'(0));
        check({tag, ".idle.in_ready"}, W'(bus.in_ready), W'(1));
    endtask

    initial begin
        logic [3:0] ops[6];
        int         n_ops;
        int         seen_valid;
        total = 0;
        bad   = 0;
        ops   = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1000, 4'b1001};
`ifdef SEQ_ALU_SRL_EN
        n_ops = 6;
`else
        n_ops = 5;
`endif
        bus.in_valid  = 1'b0;
        bus.Operation = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset.out_valid", W'(bus.out_valid), W'(0));
        check("reset.in_ready", W'(bus.in_ready), W'(1));
        check("reset.result", bus.Result, '0);
        check("reset.zero", W'(bus.Zero), W'(1));

        run_op("add_5_7", 4'b0010, 64'd5, 64'd7, 0);
        run_op("sub_9_9", 4'b0110, 64'd9, 64'd9, 0);
        run_op("and", 4'b0000, 64'hF0F0_1234_FFFF_0000, 64'h0FF0_FF00_00FF_FFFF, 0);
        run_op("or", 4'b0001, 64'hA000_0000_0000_0005, 64'h0500_0000_0000_00A0, 0);
        run_op("sub_wrap", 4'b0110, 64'd0, 64'd1, 0);
        run_op("add_wrap", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0);
        run_op("unknown_0111", 4'b0111, 64'd123, 64'd45, 0);
        run_op("sll_1_63", 4'b1000, 64'd1, 64'd63, 0);
        run_op("sll_b0", 4'b1000, 64'hDEAD_BEEF_0000_0001, 64'd0, 0);
        run_op("sll_hi_b", 4'b1000, 64'h3, 64'hFFFF_0000_0000_0044, 0);
        run_op("op_1001", 4'b1001, 64'h80, 64'd3, 0);
        run_op("backpressure", 4'b0010, 64'd100, 64'd23, 5);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("rand%0d", i), ops[$urandom_range(n_ops - 1)],
                   {$urandom, $urandom}, {$urandom, $urandom}, 0);
        end

        // Reset mid-SLL: Result currently non-zero from the previous op.
        run_op("pre_reset", 4'b0001, 64'h55, 64'h0, 0);
        @(negedge clk);
        bus.Operation = 4'b1000;
        bus.a         = 64'd1;
        bus.b         = 64'd20;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("mid_reset.out_valid", W'(bus.out_valid), W'(0));
        check("mid_reset.result", bus.Result, '0);
        check("mid_reset.zero", W'(bus.Zero), W'(1));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_reset.in_ready", W'(bus.in_ready), W'(1));
        seen_valid = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen_valid++;
        end
        check("mid_reset.no_result", W'(seen_valid), W'(0));
        run_op("post_reset_add", 4'b0010, 64'd5, 64'd7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
